battle_dp_gen: RTL

Parametrised turn-resolution datapath for the battle system; successor to the fixed 4-bit battle datapath.
- Resolves one attack per start request: move selection (player input or internal RNG for AI), table lookup of damage/accuracy, accuracy roll, saturating HP update, KO detection.
- Sits between the battle control FSM (start/attacker/move) and the HP display logic (HP/KO outputs).

---
 rtl/battle_pkg.sv | 22 ++
 rtl/battle_lfsr.sv | 26 ++
 rtl/battle_dp_gen.sv | 138 +++++++++++++
 3 files changed

// File: rtl/battle_pkg.sv
// Shared types and constants for the battle turn datapath: FSM states,
// the move table and the LFSR feedback taps.
package battle_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    LOOKUP,
    ROLL,
    APPLY,
    DONE
  } state_t;

  localparam int unsigned LFSR_W    = 16;
  localparam int unsigned TBL_W     = 4;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  // Move table, indexed by move number modulo 4.
  localparam logic [TBL_W-1:0] MOVE_DMG [4] = '{4'd3, 4'd5, 4'd7, 4'd10};
  localparam logic [TBL_W-1:0] MOVE_ACC [4] = '{4'd15, 4'd12, 4'd8, 4'd4};

endpackage

// File: rtl/battle_lfsr.sv
// 16-bit Galois LFSR with hold and load; a zero load value is replaced
// by the reset seed so the register can never lock up.
module battle_lfsr
  import battle_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] value
);

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= SEED;
    end else if (load) begin
      value <= (seed == '0) ? SEED : seed;
    end else if (!hold) begin
      value <= (value >> 1) ^ (value[0] ? LFSR_TAPS : '0);
    end
  end

endmodule

// File: rtl/battle_dp_gen.sv
// Turn-resolution datapath: move select, table lookup, accuracy roll and
// saturating HP update. Define BATTLE_CRIT_EN to enable critical hits.
module battle_dp_gen
  import battle_pkg::*;
#(
  parameter int unsigned       HP_W      = 5,
  parameter int unsigned       MAX_HP    = 15,
  parameter int unsigned       MOVE_W    = 2,
  parameter int unsigned       ACC_W     = 4,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              attacker,
  input  logic [MOVE_W-1:0] p_move,
  input  logic              rng_hold,
  input  logic              rng_load,
  input  logic [LFSR_W-1:0] rng_seed,
  output logic              busy,
  output logic              done,
  output logic              hit,
  output logic              crit,
  output logic [HP_W-1:0]   dmg,
  output logic [ACC_W-1:0]  accu,
  output logic [HP_W-1:0]   p_hp,
  output logic [HP_W-1:0]   ai_hp,
  output logic              ko_p,
  output logic              ko_ai
);

  state_t             state, state_next;
  logic [LFSR_W-1:0]  lfsr;
  logic               atk;
  logic [MOVE_W-1:0]  mv;
  logic [1:0]         idx;
  logic               roll_hit;
  logic [HP_W-1:0]    eff_dmg;
  logic [HP_W-1:0]    target;
  logic [HP_W-1:0]    target_next;
  logic               lfsr_unused;

  battle_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .hold  (rng_hold),
    .load  (rng_load),
    .seed  (rng_seed),
    .value (lfsr)
  );

  // Only a few LFSR bits feed the datapath; fold the rest away.
  assign lfsr_unused = ^lfsr;

  assign ko_p     = (p_hp == '0);
  assign ko_ai    = (ai_hp == '0);
  assign idx      = 2'(mv);
  assign roll_hit = (lfsr[ACC_W-1:0] <= accu);

`ifdef BATTLE_CRIT_EN
  logic [HP_W:0] dbl_dmg;
  assign dbl_dmg = {dmg, 1'b0};

  // Doubled damage saturates at the largest representable HP value.
  always_comb begin
    eff_dmg = dmg;
    if (crit) eff_dmg = dbl_dmg[HP_W] ? '1 : dbl_dmg[HP_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crit <= 1'b0;
    end else if (state == ROLL) begin
      crit <= roll_hit && (lfsr[15:13] == 3'b111);
    end
  end
`else
  assign eff_dmg = dmg;
  assign crit    = 1'b0;
`endif

  assign target      = atk ? p_hp : ai_hp;
  assign target_next = (eff_dmg >= target) ? '0 : target - eff_dmg;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start && !ko_p && !ko_ai) state_next = LATCH;
      LATCH:   state_next = LOOKUP;
      LOOKUP:  state_next = ROLL;
      ROLL:    state_next = APPLY;
      APPLY:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      hit   <= 1'b0;
      atk   <= 1'b0;
      mv    <= '0;
      dmg   <= '0;
      accu  <= '0;
      p_hp  <= HP_W'(MAX_HP);
      ai_hp <= HP_W'(MAX_HP);
    end else begin
      busy <= (state_next != IDLE);
      done <= (state_next == DONE);
      unique case (state)
        LATCH: begin
          atk <= attacker;
          mv  <= attacker ? lfsr[MOVE_W-1:0] : p_move;
        end
        LOOKUP: begin
          dmg  <= HP_W'(MOVE_DMG[idx]);
          accu <= ACC_W'(MOVE_ACC[idx]);
        end
        ROLL: hit <= roll_hit;
        APPLY: begin
          if (hit) begin
            if (atk) p_hp  <= target_next;
            else     ai_hp <= target_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
